// File: rtl/chip8_alu_exec.sv
// Chip-8 register/immediate execution unit: 6xkk, 7xkk and 8xyN with VF flags.
// Define CHIP8_VF_RESET_QUIRK_EN to make 8xy1/2/3 clear VF.
module chip8_alu_exec #(
  parameter int DATA_W = 8,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              cpu_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       instruction,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W-1:0] reg_addr1,
  output logic [ADDR_W-1:0] reg_addr2,
  input  logic [DATA_W-1:0] reg_readdata1,
  input  logic [DATA_W-1:0] reg_readdata2,
  output logic              reg_WE1,
  output logic              reg_WE2,
  output logic [DATA_W-1:0] reg_writedata1,
  output logic [DATA_W-1:0] reg_writedata2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              ill_q, ill_d;

  logic [3:0]        op;
  logic [3:0]        x;
  logic [3:0]        y;
  logic [3:0]        n;
  logic [7:0]        kk;
  logic [DATA_W-1:0] kk_ext;
  logic [ADDR_W-1:0] x_a;
  logic [ADDR_W-1:0] y_a;
  logic [ADDR_W-1:0] vf_a;

  assign op     = instr_q[15:12];
  assign x      = instr_q[11:8];
  assign y      = instr_q[7:4];
  assign n      = instr_q[3:0];
  assign kk     = instr_q[7:0];
  assign kk_ext = DATA_W'(kk);
  assign x_a    = ADDR_W'(x);
  assign y_a    = ADDR_W'(y);
  assign vf_a   = ADDR_W'(NREG - 1);

  logic is_ld;
  logic is_addk;
  logic is_alu;
  logic x_ok;
  logic y_ok;
  logic vf_hit;

  assign is_ld   = (op == 4'h6);
  assign is_addk = (op == 4'h7);
  assign is_alu  = (op == 4'h8);
  assign x_ok    = (int'(x) < NREG);
  assign y_ok    = (int'(y) < NREG);
  assign vf_hit  = (int'(x) == NREG - 1);

  logic legal;
  logic flag_op;
  logic dec_ill;

  always_comb begin
    legal   = 1'b0;
    flag_op = 1'b0;
    unique case (1'b1)
      is_ld, is_addk: legal = 1'b1;
      is_alu: begin
        case (n)
          4'h0: legal = 1'b1;
          4'h1, 4'h2, 4'h3: begin
            legal = 1'b1;
`ifdef CHIP8_VF_RESET_QUIRK_EN
            flag_op = 1'b1;
`else
            flag_op = 1'b0;
`endif
          end
          4'h4, 4'h5, 4'h6, 4'h7, 4'hE: begin
            legal   = 1'b1;
            flag_op = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // y is only a register index for the 8xyN group
  assign dec_ill = !legal || !x_ok || (is_alu && !y_ok);

  logic [DATA_W:0]   sum_xy;
  logic [DATA_W-1:0] sub_xy;
  logic [DATA_W-1:0] sub_yx;
  logic [DATA_W-1:0] res;
  logic              flg;

  assign sum_xy = {1'b0, a_q} + {1'b0, b_q};
  assign sub_xy = a_q - b_q;
  assign sub_yx = b_q - a_q;

  always_comb begin
    res = '0;
    flg = 1'b0;
    unique case (1'b1)
      is_ld:   res = kk_ext;
      is_addk: res = a_q + kk_ext;
      is_alu: begin
        case (n)
          4'h0: res = b_q;
          4'h1: res = a_q | b_q;
          4'h2: res = a_q & b_q;
          4'h3: res = a_q ^ b_q;
          4'h4: begin
            res = sum_xy[DATA_W-1:0];
            flg = sum_xy[DATA_W];
          end
          4'h5: begin
            res = sub_xy;
            flg = (a_q >= b_q);
          end
          4'h6: begin
            res = a_q >> 1;
            flg = a_q[0];
          end
          4'h7: begin
            res = sub_yx;
            flg = (b_q >= a_q);
          end
          4'hE: begin
            res = a_q << 1;
            flg = a_q[DATA_W-1];
          end
          default: res = '0;
        endcase
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    a_d            = a_q;
    b_d            = b_q;
    ill_d          = ill_q;
    busy           = 1'b0;
    done           = 1'b0;
    illegal        = 1'b0;
    reg_addr1      = '0;
    reg_addr2      = '0;
    reg_WE1        = 1'b0;
    reg_WE2        = 1'b0;
    reg_writedata1 = '0;
    reg_writedata2 = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          instr_d = instruction;
          ill_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        busy      = 1'b1;
        reg_addr1 = x_a;
        reg_addr2 = y_a;
        a_d       = reg_readdata1;
        b_d       = reg_readdata2;
        ill_d     = dec_ill;
        state_d   = dec_ill ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        busy           = 1'b1;
        reg_addr1      = x_a;
        reg_writedata1 = res;
        // flag write to VF wins over the Vx write when x is VF
        reg_WE1        = !(flag_op && vf_hit);
        if (flag_op) begin
          reg_addr2      = vf_a;
          reg_WE2        = 1'b1;
          reg_writedata2 = DATA_W'(flg);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        illegal = ill_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_exec.sv
// Scoreboard bench for chip8_alu_exec: directed opcodes, flags, collision,
// illegal decode, busy-start rejection and mid-instruction reset.
module tb_chip8_alu_exec;

  logic        cpu_clk;
  logic        reset_n;
  logic        start;
  logic [15:0] instruction;
  logic        busy, done, illegal;
  logic [3:0]  reg_addr1, reg_addr2;
  logic [7:0]  reg_readdata1, reg_readdata2;
  logic        reg_WE1, reg_WE2;
  logic [7:0]  reg_writedata1, reg_writedata2;

  logic [7:0] rf [16];

  assign reg_readdata1 = rf[reg_addr1];
  assign reg_readdata2 = rf[reg_addr2];

  chip8_alu_exec #(
    .DATA_W(8),
    .NREG(16),
    .ADDR_W(4)
  ) dut (
    .cpu_clk(cpu_clk),
    .reset_n(reset_n),
    .start(start),
    .instruction(instruction),
    .busy(busy),
    .done(done),
    .illegal(illegal),
    .reg_addr1(reg_addr1),
    .reg_addr2(reg_addr2),
    .reg_readdata1(reg_readdata1),
    .reg_readdata2(reg_readdata2),
    .reg_WE1(reg_WE1),
    .reg_WE2(reg_WE2),
    .reg_writedata1(reg_writedata1),
    .reg_writedata2(reg_writedata2)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

`ifdef CHIP8_VF_RESET_QUIRK_EN
  localparam int LQ = 1;
`else
  localparam int LQ = 0;
`endif

  typedef struct {
    int x, y, ill, we1, wd1, we2, wd2, lat;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] outs();
    return {33'd0, busy, done, illegal, reg_WE1, reg_WE2,
            reg_addr1, reg_addr2, reg_writedata1, reg_writedata2};
  endfunction

  int act_f, post_f, cyc, nstb;
  int ra1, ra2, s_we1, s_we2, s_wd1, s_wd2, s_a1, s_a2;

  initial begin
    act_f  = 0;
    post_f = 0;
  end

  always @(negedge cpu_clk) begin
    if (!reset_n) begin
      act_f  = 0;
      post_f = 0;
    end else begin
      if (post_f != 0) begin
        chk("idle_outputs_zero", outs(), 0);
        post_f = 0;
      end
      if (busy) begin
        if (act_f == 0) begin
          act_f = 1;
          cyc   = 0;
          nstb  = 0;
          ra1   = reg_addr1;
          ra2   = reg_addr2;
          s_we1 = 0; s_we2 = 0; s_wd1 = 0;
          s_wd2 = 0; s_a1 = 0; s_a2 = 0;
        end
        cyc++;
        if (reg_WE1 || reg_WE2) begin
          nstb++;
          s_we1 = reg_WE1;  s_wd1 = reg_writedata1;
          s_a1  = reg_addr1; s_we2 = reg_WE2;
          s_wd2 = reg_writedata2; s_a2 = reg_addr2;
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("read_addr1", ra1, e.x);
            chk("read_addr2", ra2, e.y);
            chk("latency", cyc, e.lat);
            chk("illegal", illegal, e.ill);
            chk("strobe_cycles", nstb, (e.we1 | e.we2));
            chk("we1", s_we1, e.we1);
            chk("we2", s_we2, e.we2);
            if (e.we1 != 0) begin
              chk("wd1", s_wd1, e.wd1);
              chk("wa1", s_a1, e.x);
            end
            if (e.we2 != 0) begin
              chk("wd2", s_wd2, e.wd2);
              chk("wa2", s_a2, 15);
            end
          end
          chk("done_strobes_zero",
              {reg_WE1, reg_WE2, reg_addr1, reg_addr2,
               reg_writedata1, reg_writedata2}, 0);
          act_f  = 0;
          post_f = 1;
        end
      end else if (done) begin
        chk("done_without_busy", 1, 0);
      end
    end
  end

  task automatic run(input logic [15:0] ins, input int ill,
                     input int we1, input int wd1,
                     input int we2, input int wd2, input int dbl);
    exp_t e;
    e.x   = ins[11:8];
    e.y   = ins[7:4];
    e.ill = ill;
    e.we1 = we1;
    e.wd1 = wd1;
    e.we2 = we2;
    e.wd2 = wd2;
    e.lat = (ill != 0) ? 2 : 3;
    q.push_back(e);
    @(posedge cpu_clk); #1;
    instruction = ins;
    start = 1'b1;
    @(posedge cpu_clk); #1;
    if (dbl != 0) begin
      instruction = 16'h6033;
      @(posedge cpu_clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(posedge cpu_clk); #1;
    end
    chk("idle_after_op", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    reset_n = 1'b0;
    start = 1'b0;
    instruction = 16'h0000;
    #1;
    chk("reset_outputs", outs(), 0);
    repeat (2) @(posedge cpu_clk);
    #1 reset_n = 1'b1;

    run(16'h61F0, 0, 1, 8'hF0, 0, 0, 0);
    rf[14] = 8'hC0;
    run(16'h7E54, 0, 1, 8'h14, 0, 0, 0);
    rf[1] = 8'hF0; rf[2] = 8'h20;
    run(16'h8124, 0, 1, 8'h10, 1, 1, 0);
    rf[2] = 8'h0F;
    run(16'h8124, 0, 1, 8'hFF, 1, 0, 0);
    rf[15] = 8'h05; rf[1] = 8'h03;
    run(16'h8F15, 0, 0, 0, 1, 1, 0);
    run(16'h5120, 1, 0, 0, 0, 0, 1);
    rf[1] = 8'h81;
    run(16'h8126, 0, 1, 8'h40, 1, 1, 0);
    run(16'h812E, 0, 1, 8'h02, 1, 1, 0);
    rf[1] = 8'h30; rf[2] = 8'h10;
    run(16'h8127, 0, 1, 8'hE0, 1, 0, 0);
    rf[1] = 8'h10; rf[2] = 8'h10;
    run(16'h8125, 0, 1, 8'h00, 1, 1, 0);
    rf[1] = 8'hF0; rf[2] = 8'h3C;
    run(16'h8122, 0, 1, 8'h30, LQ, 0, 0);
    rf[1] = 8'hFF; rf[2] = 8'h0F;
    run(16'h8123, 0, 1, 8'hF0, LQ, 0, 0);
    rf[2] = 8'h5A;
    run(16'h8120, 0, 1, 8'h5A, 0, 0, 0);
    run(16'h8128, 1, 0, 0, 0, 0, 0);
    rf[15] = 8'hFF;
    run(16'h7F01, 0, 1, 8'h00, 0, 0, 0);
    rf[1] = 8'h0F; rf[2] = 8'hF0;
    run(16'h8121, 0, 1, 8'hFF, LQ, 0, 0);

    rf[1] = 8'hF0; rf[2] = 8'h20;
    @(posedge cpu_clk); #1;
    instruction = 16'h8124;
    start = 1'b1;
    @(posedge cpu_clk); #1;
    start = 1'b0;
    @(posedge cpu_clk); #1;
    chk("exec_we1_before_reset", reg_WE1, 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    repeat (2) @(posedge cpu_clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge cpu_clk);
    #1;
    chk("post_reset_idle", outs(), 0);
    chk("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
